// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU: opcode encoding, sequencer states
// and a small opcode classification helper.
package alu_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD  = 2'b00;
  localparam op_t OP_SUB  = 2'b01;
  localparam op_t OP_XOR  = 2'b10;
  localparam op_t OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Arithmetic ops propagate a carry chain; logic ops do not.
  function automatic logic is_arith(input op_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/serial_alu_bit.sv
// One-bit combinational ALU slice. SUB is realised as a + ~b + cin, with the
// sequencer seeding cin=1 on the first bit. Logic ops force cout to 0.
module serial_alu_bit
  import alu_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  input  op_t  i_op,
  output logic o_r,
  output logic o_cout
);

  logic w_b;

  // Bit function and carry-out for the selected opcode
  always_comb begin
    w_b    = (i_op == OP_SUB) ? ~i_b : i_b;
    o_r    = 1'b0;
    o_cout = 1'b0;
    case (i_op)
      OP_ADD, OP_SUB: begin
        o_r    = i_a ^ w_b ^ i_cin;
        o_cout = (i_a & w_b) | (i_a & i_cin) | (w_b & i_cin);
      end
      OP_XOR:  o_r = i_a ^ i_b;
      OP_NAND: o_r = ~(i_a & i_b);
      default: o_r = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial word ALU: captures an operand pair, walks it LSB first through a
// single serial_alu_bit slice with a carry flip-flop, and publishes the
// reassembled word with a one-cycle done pulse.
// Optional feature macro: SERIAL_ALU_FLAGS_EN adds o_zero / o_overflow.
module serial_alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  op_t              i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry
`ifdef SERIAL_ALU_FLAGS_EN
  ,
  output logic             o_zero,
  output logic             o_overflow
`endif
);

  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_sh;      // partial result, fills from the MSB side
  op_t              r_op;
  logic             r_cy;      // carry between bits
  logic [WIDTH-1:0] r_res;     // published result, held between operations
  logic             r_carry;   // published carry-out

  logic             w_start_ok;
  logic             w_run;
  logic             w_last;
  logic             w_r;
  logic             w_cout;
  logic [WIDTH-1:0] w_nxt;

  assign w_start_ok = i_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_run      = (r_state == RUN);
  assign w_last     = w_run && (r_cnt == LAST);
  assign w_nxt      = {w_r, r_sh};

  serial_alu_bit u_bit (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_cy),
    .i_op   (r_op),
    .o_r    (w_r),
    .o_cout (w_cout)
  );

  // Sequencer FSM: start is only honoured in IDLE or DONE
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (i_start) r_state <= RUN;
        RUN:     if (w_last)  r_state <= DONE;
        DONE:    r_state <= i_start ? RUN : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Operand capture on start, then one shift/carry/count step per RUN cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_sh  <= '0;
      r_op  <= OP_ADD;
      r_cy  <= 1'b0;
    end else if (w_start_ok) begin
      r_cnt <= '0;
      r_a   <= i_a;
      r_b   <= i_b;
      r_op  <= i_op;
      r_cy  <= (i_op == OP_SUB);
    end else if (w_run) begin
      r_cnt <= r_cnt + CW'(1);
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_sh  <= w_nxt[WIDTH-1:1];
      r_cy  <= w_cout;
    end
  end

  // Publish result and carry on the last bit so outputs stay stable while
  // a following operation is in flight
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_res   <= '0;
      r_carry <= 1'b0;
    end else if (w_last) begin
      r_res   <= w_nxt;
      r_carry <= w_cout;
    end
  end

  assign o_busy   = w_run;
  assign o_done   = (r_state == DONE);
  assign o_result = r_res;
  assign o_carry  = r_carry;

`ifdef SERIAL_ALU_FLAGS_EN
  logic r_zacc;
  logic r_zero;
  logic r_ovf;

  // Sticky OR of result bits; overflow = carry into MSB xor carry out of MSB
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_zacc <= 1'b0;
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_start_ok) begin
      r_zacc <= 1'b0;
    end else if (w_run) begin
      r_zacc <= r_zacc | w_r;
      if (w_last) begin
        r_zero <= ~(r_zacc | w_r);
        r_ovf  <= is_arith(r_op) & (r_cy ^ w_cout);
      end
    end
  end

  assign o_zero     = r_zero;
  assign o_overflow = r_ovf;
`else
  // Flag ports and logic are not built in this configuration.
`endif

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Scoreboard bench for serial_alu_sequencer: the driver pushes hand-computed
// expectations when it issues a start; a negedge monitor pops one entry per
// done pulse and checks result, carry, timing and (when built) flags.
module tb_serial_alu_sequencer;
  import alu_pkg::*;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             start;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
`ifdef SERIAL_ALU_FLAGS_EN
  logic             zero;
  logic             overflow;
`endif

  serial_alu_sequencer #(.WIDTH(WIDTH)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_op       (op),
    .i_a        (a),
    .i_b        (b),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result),
    .o_carry    (carry)
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    .o_zero     (zero),
    .o_overflow (overflow)
`endif
  );

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             cy;
    logic             z;
    logic             ov;
    int               due;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   busy_run = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: one scoreboard entry per done pulse
  always @(negedge clk) begin
    if (busy) busy_run++;
    if (done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        chk("result",       32'(result), 32'(e.res));
        chk("carry",        32'(carry),  32'(e.cy));
        chk("done_cycle",   32'(cyc),    32'(e.due));
        chk("busy_len",     32'(busy_run), 32'(WIDTH));
        chk("busy_at_done", 32'(busy),   32'd0);
`ifdef SERIAL_ALU_FLAGS_EN
        chk("zero",         32'(zero),     32'(e.z));
        chk("overflow",     32'(overflow), 32'(e.ov));
`endif
      end
      busy_run = 0;
    end else if (!busy) begin
      busy_run = 0;
    end
  end

  // Drive start at the current negedge for one cycle; optionally expect done
  task automatic issue(input op_t o, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                       input logic [WIDTH-1:0] res, input logic cy, input logic z,
                       input logic ov, input bit push);
    exp_t x;
    start = 1'b1;
    op    = o;
    a     = xa;
    b     = xb;
    if (push) begin
      x.res = res; x.cy = cy; x.z = z; x.ov = ov; x.due = cyc + WIDTH + 1;
      sbq.push_back(x);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin seen = 1; break; end
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 40 cycles, expected one");
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, "_busy"},   32'(busy),   32'd0);
    chk({nm, "_done"},   32'(done),   32'd0);
    chk({nm, "_result"}, 32'(result), 32'd0);
    chk({nm, "_carry"},  32'(carry),  32'd0);
`ifdef SERIAL_ALU_FLAGS_EN
    chk({nm, "_zero"},     32'(zero),     32'd0);
    chk({nm, "_overflow"}, 32'(overflow), 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = OP_ADD; a = '0; b = '0;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    chk_cleared("reset");

    // Arithmetic and logic vectors: op, a, b -> result, carry, zero, overflow
    issue(OP_ADD,  8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0, 1'b1, 1); wait_done();
    @(negedge clk);
    chk("result_hold", 32'(result), 32'h96);
    idle(1);
    issue(OP_SUB,  8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0, 1); wait_done(); idle(2);
    issue(OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1); wait_done(); idle(2);
    issue(OP_XOR,  8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0, 1); wait_done(); idle(2);
    issue(OP_NAND, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1); wait_done(); idle(2);

    // Back-to-back: second start presented in the DONE cycle
    issue(OP_ADD,  8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, 1); wait_done();
    issue(OP_NAND, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1); wait_done(); idle(2);

    // Start pulsed mid-RUN with different operands must be ignored
    issue(OP_ADD,  8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0, 1);
    idle(2);
    start = 1'b1; op = OP_SUB; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(); idle(2);

    // Signed overflow with carry-out, leaves nonzero state before reset
    issue(OP_ADD,  8'h80, 8'h81, 8'h01, 1'b1, 1'b0, 1'b1, 1); wait_done(); idle(2);

    // Reset in the 4th RUN cycle: everything clears, no done for the abort
    issue(OP_ADD,  8'h70, 8'h05, 8'h75, 1'b0, 1'b0, 1'b0, 0);
    idle(3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_cleared("abort");
    idle(12);

    issue(OP_SUB,  8'h05, 8'h03, 8'h02, 1'b1, 1'b0, 1'b0, 1); wait_done(); idle(2);

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
